pe_layer_scheduler: RTL and testbench
=====================================

Name: pe_layer_scheduler

Overview:
- Global sequencer that runs the PE array layer by layer.
- On a host start it pulses pe_start_calc to all PEs, collects every PE's fin_broadcast and fin_comp, and waits for the network to drain.
- It then issues layer_done, advances layer_idx, and repeats until layer_no layers are complete.
- It sits between the host/config interface and the per-PE network interfaces; it drives the pe_start_calc and layer_done inputs of each PE controller.

Parameters:
NUM_PE, 16, number of processing elements supervised
LAYER_W, 4, width of layer count/index (matches the PE layer-number bus)
DRAIN_CYCLES, 8, consecutive net_idle cycles required before declaring a layer done (0 allowed)

Ports:
clk  input  1  system clock
rst  input  1  system reset, asynchronous, active-high
start  input  1  host start pulse (one cycle)
layer_no  input  LAYER_W  total layers; sampled only when start is accepted
pe_fin_broadcast  input  NUM_PE  per-PE one-cycle pulse: PE finished broadcasting its activations
pe_fin_comp  input  NUM_PE  per-PE one-cycle pulse: PE finished computation
net_idle  input  1  level: no flits in flight anywhere in the network
pe_start_calc  output  1  one-cycle start pulse to all PEs
layer_done  output  1  one-cycle layer-complete pulse to all PEs
layer_idx  output  LAYER_W  current layer index
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when all layers are complete
error  output  1  sticky protocol-violation flag

Behaviour:
- One clock domain. All outputs are registered or decoded from the state register; there is no combinational input-to-output path.
- Reset (async, rst=1): state=IDLE, layer_idx=0, layer_no_r=0, bcast_seen=0, comp_seen=0, drain_cnt=0, error=0. All pulse outputs are 0 and busy=0.
- States: IDLE, START, RUN, DRAIN, LDONE, FINISH.
- IDLE:
  - start=1 and layer_no!=0: latch layer_no_r, clear error, go to START.
  - start=1 and layer_no=0: go to FINISH; done is pulsed, no PE activity.
- START:
  - pe_start_calc=1 for exactly this cycle.
  - Clear bcast_seen and comp_seen; go to RUN.
- RUN:
  - Each cycle: bcast_seen |= pe_fin_broadcast and comp_seen |= pe_fin_comp.
  - fin_comp may precede fin_broadcast, and pulses from different PEs may coincide.
  - Completion test uses the merged value (seen | incoming). When both bitmaps are all ones, load drain_cnt=DRAIN_CYCLES and go to DRAIN next edge.
- DRAIN:
  - net_idle=1 and drain_cnt=0: go to LDONE.
  - net_idle=1 and drain_cnt!=0: decrement drain_cnt.
  - net_idle=0: reload drain_cnt=DRAIN_CYCLES.
  - With DRAIN_CYCLES=0, the first cycle with net_idle=1 exits DRAIN.
- LDONE:
  - layer_done=1 for exactly this cycle.
  - If layer_idx==layer_no_r-1: go to FINISH.
  - Otherwise layer_idx<=layer_idx+1 and go to START.
- FINISH:
  - done=1 for exactly this cycle; layer_idx<=0; go to IDLE.
- Error conditions (error is set and stays set until the next accepted start or reset):
  - An fin pulse on a bit already set in its bitmap during RUN.
  - Any nonzero pe_fin_broadcast or pe_fin_comp in START, DRAIN, LDONE or FINISH.
  - Fin pulses in IDLE are ignored and do not set error.
- Error does not alter sequencing; duplicates are absorbed.
- start while busy=1 is ignored, and layer_no is not resampled.
- Latency:
  - start accepted at edge N gives pe_start_calc high in cycle N+1.
  - Last fin pulse in cycle M gives DRAIN from M+1; with net_idle held high, LDONE falls in cycle M+1+DRAIN_CYCLES+1.
- drain_cnt width: clog2(DRAIN_CYCLES+1), minimum 1.
- Reset asserted mid-layer returns to IDLE immediately, with no layer_done or done pulse.

Test Plan:
- NUM_PE=4, DRAIN_CYCLES=3, layer_no=2, all fin pulses in one cycle, net_idle=1 -> per layer: pe_start_calc, then layer_done 5 cycles after the fin cycle; layer_idx 0 then 1; done one cycle after the 2nd layer_done; layer_idx returns to 0; error=0.
- Staggered fins: PEs 0..3 send fin_comp before fin_broadcast over 10 cycles; PE2 bcast arrives last -> DRAIN entered the cycle after PE2's pulse, not earlier.
- net_idle dropped for 2 cycles mid-DRAIN (cnt=1) -> counter reloads to 3; layer_done only after 4 consecutive idle cycles.
- layer_no=0 start -> done pulse 1 cycle after start (FINISH), pe_start_calc never asserted.
- Duplicate fin_comp from PE1 in RUN, and a stray fin_broadcast in DRAIN -> error=1 and held; sequencing completes normally; next start clears error.
- rst asserted in DRAIN of layer 1 of 3 -> next cycle state IDLE, layer_idx=0, busy=0, no layer_done/done; a subsequent start with layer_no=1 runs cleanly.

Source files
------------

// File: rtl/pe_layer_scheduler.sv
// pe_layer_scheduler: global layer sequencer for the PE array.
// Starts each layer, collects PE fin pulses, waits for drain, repeats.
module pe_layer_scheduler #(
  parameter int NUM_PE       = 16,
  parameter int LAYER_W      = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LAYER_W-1:0] layer_no,
  input  logic [NUM_PE-1:0]  pe_fin_broadcast,
  input  logic [NUM_PE-1:0]  pe_fin_comp,
  input  logic               net_idle,
  output logic               pe_start_calc,
  output logic               layer_done,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int DW = (DRAIN_CYCLES > 0) ?
                      $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DRAIN_LD = DW'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN,
    S_LDONE,
    S_FINISH
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [NUM_PE-1:0]  r_bcast_seen;
  logic [NUM_PE-1:0]  r_comp_seen;
  logic [NUM_PE-1:0]  w_bcast_m;
  logic [NUM_PE-1:0]  w_comp_m;
  logic [LAYER_W-1:0] r_layer_idx;
  logic [LAYER_W-1:0] r_layer_no;
  logic [DW-1:0]      r_drain_cnt;
  logic               r_error;
  logic               w_all;
  logic               w_last;
  logic               w_any_fin;
  logic               w_dup;
  logic               w_err;
  logic               w_accept;

  assign w_bcast_m = r_bcast_seen | pe_fin_broadcast;
  assign w_comp_m  = r_comp_seen | pe_fin_comp;
  assign w_all     = (&w_bcast_m) & (&w_comp_m);
  assign w_last    = (r_layer_idx == r_layer_no - LAYER_W'(1));
  assign w_any_fin = (|pe_fin_broadcast) | (|pe_fin_comp);
  assign w_dup     = (|(r_bcast_seen & pe_fin_broadcast)) |
                     (|(r_comp_seen & pe_fin_comp));
  assign w_accept  = (r_state == S_IDLE) & start;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state and protocol-violation decode
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (layer_no != '0) w_next = S_START;
          else                w_next = S_FINISH;
        end
      end
      S_START: begin
        w_err  = w_any_fin;
        w_next = S_RUN;
      end
      S_RUN: begin
        w_err = w_dup;
        if (w_all) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_err = w_any_fin;
        if (net_idle && r_drain_cnt == '0)
          w_next = S_LDONE;
      end
      S_LDONE: begin
        w_err  = w_any_fin;
        w_next = w_last ? S_FINISH : S_START;
      end
      S_FINISH: begin
        w_err  = w_any_fin;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // bitmaps, drain counter, layer index and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcast_seen <= '0;
      r_comp_seen  <= '0;
      r_drain_cnt  <= '0;
      r_layer_idx  <= '0;
      r_layer_no   <= '0;
      r_error      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_error <= 1'b0;
        if (layer_no != '0) r_layer_no <= layer_no;
      end else if (w_err) begin
        r_error <= 1'b1;
      end
      unique case (r_state)
        S_START: begin
          r_bcast_seen <= '0;
          r_comp_seen  <= '0;
        end
        S_RUN: begin
          r_bcast_seen <= w_bcast_m;
          r_comp_seen  <= w_comp_m;
          if (w_all) r_drain_cnt <= DRAIN_LD;
        end
        S_DRAIN: begin
          if (!net_idle)
            r_drain_cnt <= DRAIN_LD;
          else if (r_drain_cnt != '0)
            r_drain_cnt <= r_drain_cnt - DW'(1);
        end
        S_LDONE: begin
          if (!w_last)
            r_layer_idx <= r_layer_idx + LAYER_W'(1);
        end
        S_FINISH: r_layer_idx <= '0;
        default: ;
      endcase
    end
  end

  assign pe_start_calc = (r_state == S_START);
  assign layer_done    = (r_state == S_LDONE);
  assign done          = (r_state == S_FINISH);
  assign busy          = (r_state != S_IDLE);
  assign layer_idx     = r_layer_idx;
  assign error         = r_error;

endmodule

// File: tb/tb_pe_layer_scheduler.sv
// tb_pe_layer_scheduler: randomized self-checking bench.
// Layer timing is predicted from fin schedules and net_idle runs.
module tb_pe_layer_scheduler;

  localparam int NP = 4;
  localparam int LW = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] layer_no;
  logic [NP-1:0] fb;
  logic [NP-1:0] fc;
  logic          net_idle;
  logic          pe_start_calc;
  logic          layer_done;
  logic [LW-1:0] layer_idx;
  logic          busy;
  logic          done;
  logic          error;

  pe_layer_scheduler #(
    .NUM_PE(NP), .LAYER_W(LW), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .layer_no(layer_no),
    .pe_fin_broadcast(fb), .pe_fin_comp(fc),
    .net_idle(net_idle),
    .pe_start_calc(pe_start_calc),
    .layer_done(layer_done),
    .layer_idx(layer_idx),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ct[NP];
  int bt[NP];
  bit idle_arr[256];
  int dup_pe;
  bit stray;
  int abort_k;
  int bstart_k;
  bit exp_err;

  function automatic int max_fin();
    int m = 0;
    for (int p = 0; p < NP; p++) begin
      if (ct[p] > m) m = ct[p];
      if (bt[p] > m) m = bt[p];
    end
    return m;
  endfunction

  // layer_done comes the cycle after the first run of DC+1
  // consecutive idle cycles that starts after the last fin
  function automatic int model_ldone();
    int run = 0;
    for (int t = max_fin() + 1; t < 256; t++) begin
      run = idle_arr[t] ? run + 1 : 0;
      if (run == DC + 1) return t + 1;
    end
    return -1;
  endfunction

  task automatic gen(input int scen);
    int m;
    dup_pe = -1; stray = 0; abort_k = -1; bstart_k = -1;
    for (int t = 0; t < 256; t++) idle_arr[t] = 1'b1;
    for (int p = 0; p < NP; p++) begin
      ct[p] = 1; bt[p] = 1;
    end
    if (scen == 1 || scen == 4) begin
      m = 0;
      for (int p = 0; p < NP; p++) begin
        ct[p] = $urandom_range(1, 4);
        bt[p] = ct[p] + $urandom_range(1, 5);
        if (p != 2 && bt[p] > m) m = bt[p];
      end
      if (bt[2] <= m) bt[2] = m + 1;
      if (scen == 4) begin dup_pe = 1; stray = 1; end
    end else if (scen == 2) begin
      idle_arr[max_fin() + 3] = 1'b0;
      idle_arr[max_fin() + 4] = 1'b0;
    end else if (scen == 3) begin
      for (int p = 0; p < NP; p++) begin
        ct[p] = $urandom_range(1, 8);
        bt[p] = $urandom_range(1, 8);
      end
      for (int t = 0; t < max_fin() + 14; t++)
        idle_arr[t] = ($urandom_range(0, 3) != 0);
      bstart_k = $urandom_range(1, 6);
    end
  endtask

  // status: 0 ok, 1 reset applied, 2 timeout
  task automatic run_layer(input int idx, output int status);
    int L, M, w;
    logic [3:0] ev, gv;
    status = 0;
    M = max_fin();
    L = model_ldone();
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (pe_start_calc !== 1'b1 && w < 8);
    checks++;
    if (pe_start_calc !== 1'b1 || layer_idx !== LW'(idx) ||
        error !== exp_err) begin
      errors++;
      $display("FAIL layer_start idx=%0d: psc=%b idx=%0d err=%b, want psc=1 idx=%0d err=%b",
               idx, pe_start_calc, layer_idx, error, idx, exp_err);
      if (pe_start_calc !== 1'b1) begin
        status = 2;
        return;
      end
    end
    start = 1'b0; fb = '0; fc = '0; net_idle = 1'b1;
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      ev = {(k == L), 1'b0, 1'b0, 1'b1};
      gv = {layer_done, pe_start_calc, done, busy};
      checks++;
      if (gv !== ev || layer_idx !== LW'(idx)) begin
        errors++;
        $display("FAIL layer_cycle idx=%0d k=%0d: {ld,psc,done,busy}=%b idx=%0d, want %b idx=%0d",
                 idx, k, gv, layer_idx, ev, idx);
      end
      if (k == L) begin
        if (dup_pe >= 0 || stray) exp_err = 1'b1;
        break;
      end
      fb = '0; fc = '0;
      for (int p = 0; p < NP; p++) begin
        if (bt[p] == k) fb[p] = 1'b1;
        if (ct[p] == k) fc[p] = 1'b1;
      end
      if (dup_pe >= 0 && k == ct[dup_pe] + 1) fc[dup_pe] = 1'b1;
      if (stray && k == M + 1) fb[0] = 1'b1;
      net_idle = idle_arr[k];
      start = (k == bstart_k);
      layer_no = LW'($urandom_range(1, 15));
      if (k == abort_k) begin
        rst = 1'b1;
        status = 1;
        return;
      end
    end
    fb = '0; fc = '0; start = 1'b0; net_idle = 1'b1;
    checks++;
    if (error !== exp_err) begin
      errors++;
      $display("FAIL layer_error idx=%0d: error=%b, want %b",
               idx, error, exp_err);
    end
  endtask

  task automatic run_job(input int n, input int scen,
                         input int ab_layer);
    int st;
    @(negedge clk);
    start = 1'b1;
    layer_no = LW'(n);
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      gen(scen);
      if (i == ab_layer) abort_k = max_fin() + 2;
      run_layer(i, st);
      if (st == 2) begin
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        return;
      end
      if (st == 1) begin
        fb = '0; fc = '0; start = 1'b0;
        @(negedge clk);
        checks++;
        if ({layer_done, done, busy, pe_start_calc} !== 4'b0 ||
            layer_idx !== '0) begin
          errors++;
          $display("FAIL reset_mid: {ld,done,busy,psc}=%b idx=%0d, want 0000 idx=0",
                   {layer_done, done, busy, pe_start_calc}, layer_idx);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({layer_done, done, busy} !== 3'b0) begin
          errors++;
          $display("FAIL reset_release: {ld,done,busy}=%b, want 000",
                   {layer_done, done, busy});
        end
        return;
      end
    end
    @(negedge clk);
    checks++;
    if ({layer_done, pe_start_calc, done, busy} !== 4'b0011 ||
        layer_idx !== LW'(n - 1) || error !== exp_err) begin
      errors++;
      $display("FAIL finish: {ld,psc,done,busy}=%b idx=%0d err=%b, want 0011 idx=%0d err=%b",
               {layer_done, pe_start_calc, done, busy}, layer_idx,
               error, n - 1, exp_err);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00 || layer_idx !== '0) begin
      errors++;
      $display("FAIL idle_after: done=%b busy=%b idx=%0d, want 0 0 0",
               done, busy, layer_idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; layer_no = '0;
    fb = '0; fc = '0; net_idle = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({pe_start_calc, layer_done, done, busy, error} !== 5'b0 ||
        layer_idx !== '0) begin
      errors++;
      $display("FAIL reset: outs=%b idx=%0d, want 00000 idx=0",
               {pe_start_calc, layer_done, done, busy, error},
               layer_idx);
    end
    fb = 4'b1111; fc = 4'b0101;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    fb = '0; fc = '0;
    checks++;
    if ({busy, error} !== 2'b00) begin
      errors++;
      $display("FAIL idle_fins: busy=%b error=%b, want 0 0",
               busy, error);
    end
  endtask

  task automatic test_uniform();
    run_job(2, 0, -1);
  endtask

  task automatic test_staggered();
    run_job(2, 1, -1);
  endtask

  task automatic test_drain_reload();
    run_job(1, 2, -1);
  endtask

  task automatic test_zero_layers();
    @(negedge clk);
    start = 1'b1; layer_no = '0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({layer_done, pe_start_calc, done, busy} !== 4'b0011) begin
      errors++;
      $display("FAIL zero_finish: {ld,psc,done,busy}=%b, want 0011",
               {layer_done, pe_start_calc, done, busy});
    end
    @(negedge clk);
    checks++;
    if ({layer_done, pe_start_calc, done, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL zero_idle: {ld,psc,done,busy}=%b, want 0000",
               {layer_done, pe_start_calc, done, busy});
    end
  endtask

  task automatic test_errors();
    run_job(2, 4, -1);
    run_job(1, 0, -1);
  endtask

  task automatic test_reset_mid();
    run_job(3, 0, 1);
    run_job(1, 0, -1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(1, 3), 3, -1);
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_staggered();
    test_drain_reload();
    test_zero_layers();
    test_errors();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
